// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request outstanding and
// delivers {ins, pc_out, ins_valid} to IF/ID, with a 1-entry skid buffer for stalled responses.
module if_fetch #(
    parameter int                     WordSize = 32,
    parameter logic [WordSize-1:0]    ResetPC  = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] branch_target,
    output logic                imem_req,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ins,
    output logic [WordSize-1:0] pc_out,
    output logic                ins_valid,
    output logic [1:0]          state_dbg
);

    // Handshakes: a request transfers when imem_req && imem_gnt; imem_rvalid is a one-cycle
    // data strobe with no backpressure; a word transfers to IF/ID when ins_valid && !stall.
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    localparam logic [WordSize-1:0] PcStep    = WordSize'(4);
    localparam logic [WordSize-1:0] AlignMask = ~WordSize'(3);

    state_t              state, state_n;
    logic [WordSize-1:0] pc, pc_n;
    logic [WordSize-1:0] inflight_pc, inflight_pc_n;
    logic                squash, squash_n;
    logic [31:0]         skid_ins, skid_ins_n;
    logic [WordSize-1:0] skid_pc, skid_pc_n;
    logic                skid_valid, skid_valid_n;
    logic [31:0]         ins_n;
    logic [WordSize-1:0] pc_out_n;
    logic                ins_valid_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= ResetPC;
            inflight_pc <= '0;
            squash      <= 1'b0;
            skid_ins    <= '0;
            skid_pc     <= '0;
            skid_valid  <= 1'b0;
            ins         <= '0;
            pc_out      <= '0;
            ins_valid   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            inflight_pc <= inflight_pc_n;
            squash      <= squash_n;
            skid_ins    <= skid_ins_n;
            skid_pc     <= skid_pc_n;
            skid_valid  <= skid_valid_n;
            ins         <= ins_n;
            pc_out      <= pc_out_n;
            ins_valid   <= ins_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        inflight_pc_n = inflight_pc;
        squash_n      = squash;
        skid_ins_n    = skid_ins;
        skid_pc_n     = skid_pc;
        skid_valid_n  = skid_valid;
        ins_n         = ins;
        pc_out_n      = pc_out;
        ins_valid_n   = ins_valid;
        imem_req      = 1'b0;

        if (ins_valid && !stall) begin
            ins_valid_n = 1'b0;
        end

        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    inflight_pc_n = pc;
                    pc_n          = pc + PcStep;
                    state_n       = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (squash) begin
                        squash_n = 1'b0;
                        state_n  = FETCH;
                    end else if (!ins_valid || !stall) begin
                        ins_n       = imem_rdata;
                        pc_out_n    = inflight_pc;
                        ins_valid_n = 1'b1;
                        state_n     = FETCH;
                    end else begin
                        skid_ins_n   = imem_rdata;
                        skid_pc_n    = inflight_pc;
                        skid_valid_n = 1'b1;
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    ins_n        = skid_ins;
                    pc_out_n     = skid_pc;
                    ins_valid_n  = 1'b1;
                    skid_valid_n = 1'b0;
                    state_n      = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase

        // Redirect overrides everything above; a granted-but-unanswered request gets squashed.
        if (branch_taken) begin
            pc_n         = branch_target & AlignMask;
            ins_n        = ins;
            pc_out_n     = pc_out;
            ins_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
            case (state)
                FETCH: begin
                    squash_n = imem_gnt;
                    state_n  = imem_gnt ? WAIT : FETCH;
                end
                WAIT: begin
                    squash_n = !imem_rvalid;
                    state_n  = imem_rvalid ? FETCH : WAIT;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    assign imem_addr = pc;
    assign state_dbg = state;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: one instance at ResetPC=0 and one at ResetPC=0xFFFFFFFC
// driven from a single linear sequence of steps.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req, imem_gnt, imem_rvalid, ins_valid;
    logic [31:0] imem_addr, imem_rdata, ins, pc_out;
    logic [1:0]  state_dbg;

    logic        imem_req2, imem_gnt2, imem_rvalid2, ins_valid2;
    logic [31:0] imem_addr2, imem_rdata2, ins2, pc_out2;
    logic [1:0]  state_dbg2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch #(.WordSize(32), .ResetPC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins(ins), .pc_out(pc_out), .ins_valid(ins_valid), .state_dbg(state_dbg)
    );

    if_fetch #(.WordSize(32), .ResetPC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rstn(rstn), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .ins(ins2), .pc_out(pc_out2), .ins_valid(ins_valid2), .state_dbg(state_dbg2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        imem_gnt2 = 1'b0; imem_rvalid2 = 1'b0; imem_rdata2 = '0;
        repeat (3) step();

        // Reset values
        check("rst_ins", ins, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_valid", {31'b0, ins_valid}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_state", {30'b0, state_dbg}, 32'h0);
        check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

        // 1: basic fetch
        rstn = 1'b1;
        step();
        check("t1_req", {31'b0, imem_req}, 32'h1);
        check("t1_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t1_wait_req", {31'b0, imem_req}, 32'h0);
        check("t1_wait_valid", {31'b0, ins_valid}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        check("t1_ins", ins, 32'h0050_0093);
        check("t1_pc_out", pc_out, 32'h0);
        check("t1_valid", {31'b0, ins_valid}, 32'h1);
        check("t1_next_addr", imem_addr, 32'h4);
        check("t1_next_req", {31'b0, imem_req}, 32'h1);

        // 2: response during stall goes to skid
        stall = 1'b1; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t2_hold_valid", {31'b0, ins_valid}, 32'h1);
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0;
        check("t2_hold_state", {30'b0, state_dbg}, 32'h3);
        check("t2_hold_ins", ins, 32'h0050_0093);
        check("t2_hold_req", {31'b0, imem_req}, 32'h0);
        step();
        check("t2_still_ins", ins, 32'h0050_0093);
        check("t2_still_pc", pc_out, 32'h0);
        stall = 1'b0;
        step();
        check("t2_ins", ins, 32'h00A0_0113);
        check("t2_pc_out", pc_out, 32'h4);
        check("t2_valid", {31'b0, ins_valid}, 32'h1);
        check("t2_addr", imem_addr, 32'h8);
        check("t2_req", {31'b0, imem_req}, 32'h1);

        // 3: branch while waiting drops the stale response
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t3_consumed", {31'b0, ins_valid}, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        check("t3_wait_req", {31'b0, imem_req}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("t3_dropped", {31'b0, ins_valid}, 32'h0);
        check("t3_addr", imem_addr, 32'h100);
        check("t3_req", {31'b0, imem_req}, 32'h1);

        // 4a: branch same cycle as gnt
        imem_gnt = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        imem_gnt = 1'b0; branch_taken = 1'b0;
        check("t4a_req", {31'b0, imem_req}, 32'h0);
        step();
        check("t4a_no_req_pending", {31'b0, imem_req}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        step();
        imem_rvalid = 1'b0;
        check("t4a_dropped", {31'b0, ins_valid}, 32'h0);
        check("t4a_addr", imem_addr, 32'h200);
        check("t4a_req2", {31'b0, imem_req}, 32'h1);

        // 4b: branch same cycle as rvalid
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        imem_rvalid = 1'b0; branch_taken = 1'b0;
        check("t4b_dropped", {31'b0, ins_valid}, 32'h0);
        check("t4b_addr", imem_addr, 32'h200);
        check("t4b_req", {31'b0, imem_req}, 32'h1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        check("t4b_ins", ins, 32'h1111_1111);
        check("t4b_pc_out", pc_out, 32'h200);
        check("t4b_valid", {31'b0, ins_valid}, 32'h1);

        // Branch overrides stall on the output register
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        check("br_stall_valid", {31'b0, ins_valid}, 32'h0);
        check("br_stall_addr", imem_addr, 32'h300);

        // 6: reset during WAIT
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t6_wait_req", {31'b0, imem_req}, 32'h0);
        rstn = 1'b0;
        #1;
        check("t6_ins", ins, 32'h0);
        check("t6_pc_out", pc_out, 32'h0);
        check("t6_valid", {31'b0, ins_valid}, 32'h0);
        check("t6_req", {31'b0, imem_req}, 32'h0);
        check("t6_addr", imem_addr, 32'h0);
        step();
        rstn = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
        step();
        check("t6_late_valid", {31'b0, ins_valid}, 32'h0);
        check("t6_first_req", {31'b0, imem_req}, 32'h1);
        check("t6_first_addr", imem_addr, 32'h0);
        step();
        imem_rvalid = 1'b0;
        check("t6_late_valid2", {31'b0, ins_valid}, 32'h0);

        // 5: PC wrap on the second instance
        check("t5_addr0", imem_addr2, 32'hFFFF_FFFC);
        check("t5_req0", {31'b0, imem_req2}, 32'h1);
        imem_gnt2 = 1'b1;
        step();
        imem_gnt2 = 1'b0;
        imem_rvalid2 = 1'b1; imem_rdata2 = 32'h0000_0013;
        step();
        imem_rvalid2 = 1'b0;
        check("t5_ins", ins2, 32'h0000_0013);
        check("t5_pc_out", pc_out2, 32'hFFFF_FFFC);
        check("t5_valid", {31'b0, ins_valid2}, 32'h1);
        check("t5_addr1", imem_addr2, 32'h0);
        check("t5_req1", {31'b0, imem_req2}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
